// File: rtl/sync_evt_arb.sv
// sync_evt_arb: synchronizes async inputs, detects per-channel edges, latches pending events
// and offers them one at a time round-robin on a valid/ready port.
// Optional feature macro: SYNC_EVT_ARB_OVF_EN adds sticky per-channel overflow flags (ovf_o, ovf_clr_i).
module sync_evt_arb #(
    parameter int num_p       = 4,
    parameter int stages_p    = 2,
    parameter int idx_width_p = $clog2(num_p)
) (
    input  logic                   main_clk_i,
    input  logic                   main_rst_an_i,
    input  logic [num_p-1:0]       data_i,
    input  logic [2*num_p-1:0]     edge_i,
`ifdef SYNC_EVT_ARB_OVF_EN
    output logic [num_p-1:0]       ovf_o,
    input  logic                   ovf_clr_i,
`endif
    output logic                   evt_valid_o,
    input  logic                   evt_ready_i,
    output logic [idx_width_p-1:0] evt_idx_o,
    output logic [num_p-1:0]       pend_o
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t                         state_q;
    logic [stages_p-1:0][num_p-1:0] sync_q;
    logic [num_p-1:0]               prev_q, pend_q, pend_d, det, clr, sync_s;
    logic [2:0]                     wu_q;
    logic [idx_width_p-1:0]         idx_q, idx_d, rr_q, rr_nxt;
    logic                           valid_q, hs, wu_done;

    assign sync_s      = sync_q[stages_p-1];
    assign wu_done     = wu_q == 3'(stages_p + 1);
    assign hs          = valid_q & evt_ready_i;
    assign clr         = hs ? num_p'(1) << idx_q : '0;
    assign pend_d      = det | (pend_q & ~clr);
    assign rr_nxt      = (int'(idx_q) == num_p - 1) ? '0 : idx_q + 1'b1;
    assign evt_valid_o = valid_q;
    assign evt_idx_o   = idx_q;
    assign pend_o      = pend_q;

    // Edge detection per channel, masked until the history flops hold synchronized data
    always_comb begin
        det = '0;
        for (int n = 0; n < num_p; n++)
            det[n] = wu_done & ((edge_i[2*n +: 2] == 2'd1 & sync_s[n] & ~prev_q[n]) |
                                (edge_i[2*n +: 2] == 2'd2 & ~sync_s[n] & prev_q[n]));
    end

    // Round-robin pick: lowest pending at or above rr_q wins, otherwise lowest below it
    always_comb begin
        idx_d = '0;
        for (int n = num_p - 1; n >= 0; n--)
            if (pend_q[n] && n < int'(rr_q)) idx_d = idx_width_p'(n);
        for (int n = num_p - 1; n >= 0; n--)
            if (pend_q[n] && n >= int'(rr_q)) idx_d = idx_width_p'(n);
    end

    // Synchronizer chain, edge history, warm-up mask and pending flags
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            sync_q <= '0;
            prev_q <= '0;
            wu_q   <= '0;
            pend_q <= '0;
        end else begin
            sync_q <= {sync_q[stages_p-2:0], data_i};
            prev_q <= sync_s;
            wu_q   <= wu_done ? wu_q : wu_q + 1'b1;
            pend_q <= pend_d;
        end
    end

    // Arbiter FSM: IDLE loads the next channel, OFFER holds it until the handshake
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            rr_q    <= '0;
        end else if (state_q == IDLE) begin
            if (|pend_q) begin
                state_q <= OFFER;
                valid_q <= 1'b1;
                idx_q   <= idx_d;
            end
        end else if (evt_ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            rr_q    <= rr_nxt;
        end
    end

`ifdef SYNC_EVT_ARB_OVF_EN
    logic [num_p-1:0] ovf_q;
    assign ovf_o = ovf_q;

    // Sticky overflow: an edge on an already pending channel not being cleared this cycle
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) ovf_q <= '0;
        else                ovf_q <= (ovf_clr_i ? '0 : ovf_q) | (det & pend_q & ~clr);
    end
`endif
endmodule

// File: tb/tb_sync_evt_arb.sv
// tb_sync_evt_arb: directed bench; expected event indices go into a scoreboard queue and a
// monitor checks each handshake against it.
module tb_sync_evt_arb;
    localparam int N = 4;
    logic           clk = 1'b0, rst_n = 1'b0, ready = 1'b0;
    logic [N-1:0]   data = '1;
    logic [2*N-1:0] edge_s = 8'h55;
    logic           valid;
    logic [1:0]     idx;
    logic [N-1:0]   pend;
`ifdef SYNC_EVT_ARB_OVF_EN
    logic [N-1:0]   ovf;
    logic           ovf_clr = 1'b0;
`endif
    int passed = 0, total = 0, cyc = 0, c0 = 0, bad = 0, e_mon = 0;
    int exp_q[$];
    int hs_cyc[$];

    sync_evt_arb dut (
        .main_clk_i   (clk),
        .main_rst_an_i(rst_n),
        .data_i       (data),
        .edge_i       (edge_s),
`ifdef SYNC_EVT_ARB_OVF_EN
        .ovf_o        (ovf),
        .ovf_clr_i    (ovf_clr),
`endif
        .evt_valid_o  (valid),
        .evt_ready_i  (ready),
        .evt_idx_o    (idx),
        .pend_o       (pend)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(5);
    endtask

    task automatic burst_timing(input int n);
        chk("hs_count", hs_cyc.size(), n);
        if (hs_cyc.size() == n) begin
            chk("hs_latency", hs_cyc[0] - c0, 4);
            for (int i = 1; i < n; i++) chk("hs_gap", hs_cyc[i] - hs_cyc[i-1], 2);
        end
    endtask

    // Monitor: every accepted event must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            e_mon = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            chk("evt_idx", int'(idx), e_mon);
            hs_cyc.push_back(cyc);
        end
    end

    initial begin
        // Reset with inputs high and pos edges: nothing may fire
        step(2);
        chk("rst_valid", int'(valid), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_pend", int'(pend), 0);
`ifdef SYNC_EVT_ARB_OVF_EN
        chk("rst_ovf", int'(ovf), 0);
`endif
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid || pend != 0) bad++;
        end
        chk("no_false_edge", bad, 0);

        // Ch2 pos edge: latency and single handshake
        data = 4'hB;
        step(4);
        chk("fall_no_pend", int'(pend), 0);
        data = 4'hF;
        exp_q.push_back(2);
        step(2);
        chk("ch2_pend_early", int'(pend), 0);
        step();
        chk("ch2_pend", int'(pend), 4);
        chk("ch2_valid_early", int'(valid), 0);
        ready = 1'b1;
        step();
        chk("ch2_valid", int'(valid), 1);
        chk("ch2_idx", int'(idx), 2);
        step();
        chk("ch2_pend_clr", int'(pend), 0);
        chk("ch2_valid_clr", int'(valid), 0);

        // All neg, simultaneous fall from rr_ptr 0
        ready = 1'b0;
        edge_s = 8'hAA;
        do_reset();
        ready = 1'b1;
        hs_cyc.delete();
        c0 = cyc;
        data = 4'h0;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        step(12);
        burst_timing(4);

        // Move rr_ptr to 2 with a single ch1 event, then repeat the burst
        edge_s = 8'h04;
        exp_q.push_back(1);
        data = 4'hF;
        step(6);
        edge_s = 8'hAA;
        step();
        hs_cyc.delete();
        c0 = cyc;
        data = 4'h0;
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
        step(12);
        burst_timing(4);

        // Stalled consumer: index held, second edge on ch3 is lost
        ready = 1'b0;
        edge_s = 8'h40;
        step();
        data = 4'h8;
        exp_q.push_back(3);
        step(4);
        chk("stall_valid", int'(valid), 1);
        chk("stall_idx", int'(idx), 3);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) data = 4'h0;
            if (i == 3) data = 4'h8;
            step();
            if (!valid || idx != 2'd3) bad++;
        end
        chk("stall_hold", bad, 0);
        chk("stall_pend", int'(pend), 8);
`ifdef SYNC_EVT_ARB_OVF_EN
        chk("ovf_set", int'(ovf), 8);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", int'(ovf), 0);
`endif
        ready = 1'b1;
        step();
        chk("stall_pend_clr", int'(pend), 0);

        // Handshake on ch1 in the same cycle as a new ch1 edge
        ready = 1'b0;
        edge_s = 8'h04;
        step();
        data = 4'hA;
        exp_q.push_back(1); exp_q.push_back(1);
        step(4);
        data = 4'h8;
        step(3);
        data = 4'hA;
        step(2);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("coll_pend", int'(pend), 2);
        chk("coll_valid_gap", int'(valid), 0);
        step();
        chk("coll_reoffer", int'(valid), 1);
        chk("coll_idx", int'(idx), 1);
`ifdef SYNC_EVT_ARB_OVF_EN
        chk("coll_ovf", int'(ovf), 0);
`endif
        ready = 1'b1;
        step(2);
        chk("coll_pend_clr", int'(pend), 0);

        // Reset while offering: event discarded, nothing after release
        ready = 1'b0;
        edge_s = 8'h01;
        step();
        data = 4'hB;
        step(4);
        chk("pre_rst_valid", int'(valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_pend", int'(pend), 0);
        step(2);
        rst_n = 1'b1;
        ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (valid) bad++;
        end
        chk("post_rst_quiet", bad, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sync_evt_arb.md
# sync_evt_arb

Multi-channel event controller built around the `sync` datapath. It synchronizes `num_p` asynchronous inputs into `main_clk_i`, detects the configured edge on each channel (no, pos, neg), and latches each detection as a pending event. A round-robin arbiter then hands the events one at a time to a single valid/ready consumer, typically an interrupt or register block. It sits between asynchronous pins or foreign-domain strobes and the core event/IRQ logic.

## Interface
Parameters:
- `num_p`, 4: number of channels, legal range 2..16.
- `stages_p`, 2: synchronizer flop stages per channel, legal range 2..4.
- `idx_width_p`, `$clog2(num_p)`: width of the channel index. Derived; do not override.

Ports:
- `main_clk_i`  in  1  Clock.
- `main_rst_an_i`  in  1  Async reset, active low.
- `data_i`  in  num_p  Asynchronous channel inputs.
- `edge_i`  in  2*num_p  Per-channel edge select, 2 bits per channel, channel n at `[2n+1:2n]`. Encoding: 0 = no, 1 = pos, 2 = neg, 3 = treated as no.
- `evt_valid_o`  out  1  Event offered.
- `evt_ready_i`  in  1  Consumer accepts the offered event.
- `evt_idx_o`  out  idx_width_p  Channel of the offered event.
- `pend_o`  out  num_p  Pending flags.
- `ovf_o`  out  num_p  Sticky overflow flags. Present only with `SYNC_EVT_ARB_OVF_EN`.
- `ovf_clr_i`  in  1  Clears all `ovf_o` flags. Present only with `SYNC_EVT_ARB_OVF_EN`.

## Operation
- Per channel: a `stages_p`-deep synchronizer, followed by a history flop `prev_q`, followed by edge detection.
  - pos: `sync & ~prev`.
  - neg: `~sync & prev`.
- Warm-up counter: after reset release, detection is masked for `stages_p + 1` cycles while the history flops fill. This prevents false edges when an input is already high at reset release.
- A detected edge sets `pend_q[n]`.
- Changing `edge_i` never clears `pend_q`. It only affects detection from the next cycle on.
- Arbiter FSM has two states:
  - IDLE: if `pend_q` is nonzero, select the first set bit at or after `rr_ptr_q`, searching upward and wrapping at `num_p-1` → 0. Load `evt_idx_o`, then go to OFFER.
  - OFFER: `evt_valid_o = 1`. `evt_idx_o` is held stable until `evt_valid_o & evt_ready_i`. On that handshake:
    - clear `pend_q[idx]`;
    - set `rr_ptr_q = idx + 1`, wrapping to 0 after `num_p-1`;
    - go to IDLE.
- Simultaneous handshake and new edge on the same channel: the new edge wins. `pend_q[idx]` stays set and is not counted as an overflow.
- Edge on a channel whose `pend_q` is already set, with no same-cycle handshake: the event is lost. `pend_q` stays set; the overflow flag is set if compiled in.
- `evt_ready_i` in IDLE is ignored.
- Reset mid-offer: all state returns to reset values immediately and the offered event is discarded.

## Timing
- Reset values:
  - `evt_valid_o` = 0, `evt_idx_o` = 0, `pend_o` = 0, `ovf_o` = 0;
  - `rr_ptr_q` = 0, FSM = IDLE;
  - synchronizer and history flops = 0;
  - warm-up counter = 0 (detection masked).
- Latency: an input transition set up before clock edge k appears in `pend_o` after edge k+`stages_p`, and in `evt_valid_o` one cycle later.
- Throughput: at most one event per 2 cycles (IDLE→OFFER→IDLE).
- `evt_valid_o` and `evt_idx_o` are registered. No combinational path from `evt_ready_i` to any output.
- Minimum pulse width on `data_i` for guaranteed detection: 2 clock periods.

## Configuration
- `SYNC_EVT_ARB_OVF_EN` defined:
  - `ovf_o` and `ovf_clr_i` exist;
  - `ovf_q[n]` sets on a lost event;
  - `ovf_clr_i` clears all flags next cycle; a set in the same cycle as a clear wins.
- `SYNC_EVT_ARB_OVF_EN` undefined: the ports and flops are absent and lost events are silently dropped.

## Test plan
- Reset with `data_i = 4'hF`, `edge_i` all pos → no pending and no `evt_valid_o` ever asserted.
- Ch2 pos, rising `data_i[2]` → `pend_o = 4'h4` after `stages_p` edges; `evt_valid_o = 1`, `evt_idx_o = 2` one cycle later. With `evt_ready_i = 1`, `pend_o = 0` the next cycle.
- All channels neg, all inputs fall simultaneously, `evt_ready_i` held 1 → events delivered in idx order 0,1,2,3, 2 cycles apart. Repeat with `rr_ptr_q = 2` → order 2,3,0,1.
- `evt_ready_i = 0` for 10 cycles → `evt_idx_o` is stable; a second edge on the same channel sets `ovf_o[idx]` (OVF_EN build); `ovf_clr_i` clears it.
- Handshake on ch1 in the same cycle as a new ch1 edge → `pend_o[1]` stays 1 and ch1 is offered again; `ovf_o` = 0.
- Assert reset during OFFER → `evt_valid_o = 0` and `pend_o = 0` immediately; no event is delivered after release.
